response_pop_fsm: RTL and testbench

- Drains the B FIFO and R FIFO that the response push FSM fills, and drives the AXI4 slave B and R channels toward the master.
- Each channel has its own prefetching 2-entry output buffer, so it sustains one beat per cycle and holds its payload stable under backpressure.
- Tracks R bursts: beat count, active flag, and a sticky overrun error when RLAST is missing.

---
 rtl/response_pop_fsm_pkg.sv | 40 ++++
 rtl/response_pop_fsm_resp_channel_pop.sv | 67 ++++++
 rtl/response_pop_fsm.sv | 115 +++++++++++
 tb/tb_response_pop_fsm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/response_pop_fsm_pkg.sv
// Shared types and constants for the AXI response pop engines.
package response_pop_fsm_pkg;

  localparam int ID_W      = 7;
  localparam int DATA_W    = 1024;
  localparam int MAX_BEATS = 32;
  localparam int CNT_W     = 6;

  // B FIFO word: {BID, BRESP}
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_entry_t;

  // R FIFO word: {RID, RDATA, RRESP, RLAST}; last sits at bit 0 to match the push side
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_entry_t;

  // Output buffer occupancy
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pop_state_t;

  // Map a projected word count onto the occupancy encoding
  function automatic pop_state_t occ_from_level(input logic [1:0] level);
    case (level)
      2'd0:    return EMPTY;
      2'd1:    return ONE;
      2'd2:    return TWO;
      default: return EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/response_pop_fsm_resp_channel_pop.sv
// Prefetching 2-entry output buffer between a registered-read FIFO and an AXI channel.
module resp_channel_pop
  import response_pop_fsm_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] payload
);

  pop_state_t       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             pop_s;
  logic [1:0]       level_s;

  // Outputs: valid and payload come only from flops; rd_en is the lone ready-to-rd_en path
  always_comb begin
    valid      = (occ_q != EMPTY);
    pop_s      = valid & ready;
    level_s    = 2'(occ_q) + {1'b0, inflight_q} - {1'b0, pop_s};
    fifo_rd_en = ~fifo_empty & (level_s < 2'd2);
    payload    = mem_q[head_q];
  end

  // Next state: land the in-flight word at tail, retire head on pop
  always_comb begin
    occ_d      = occ_from_level(level_s);
    inflight_d = fifo_rd_en;
    head_d     = head_q ^ pop_s;
    tail_d     = tail_q ^ inflight_q;
    mem_d      = mem_q;
    if (inflight_q) begin
      mem_d[tail_q] = fifo_rd_data;
    end else begin
      mem_d[tail_q] = mem_q[tail_q];
    end
  end

  // State register; reset drops buffered and in-flight words
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: rtl/response_pop_fsm.sv
// Drains the B and R response FIFOs onto the AXI slave B/R channels and tracks R bursts.
module response_pop_fsm
  import response_pop_fsm_pkg::*;
#(
  parameter int ID_WIDTH   = ID_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic                           B_FIFO_empty,
  output logic                           B_FIFO_rd_en,
  input  logic [ID_WIDTH+1:0]            B_FIFO_rd_data,
  input  logic                           R_FIFO_empty,
  output logic                           R_FIFO_rd_en,
  input  logic [ID_WIDTH+DATA_WIDTH+2:0] R_FIFO_rd_data,
  output logic [ID_WIDTH-1:0]            BID,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [ID_WIDTH-1:0]            RID,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RLAST,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic                           r_burst_active,
  output logic [CNT_W-1:0]               r_beat_count,
  output logic                           r_last_err
);

  localparam int B_ENTRY_WIDTH = ID_WIDTH + 2;
  localparam int R_ENTRY_WIDTH = ID_WIDTH + DATA_WIDTH + 3;

  logic [B_ENTRY_WIDTH-1:0] b_payload_s;
  logic [R_ENTRY_WIDTH-1:0] r_payload_s;
  logic                     r_pop_s;
  logic [CNT_W-1:0]         r_beat_count_q, r_beat_count_d;
  logic                     r_burst_active_q, r_burst_active_d;
  logic                     r_last_err_q, r_last_err_d;

  resp_channel_pop #(.WIDTH(B_ENTRY_WIDTH)) u_b_pop (
    .clk          (clk),
    .arst         (arst),
    .fifo_empty   (B_FIFO_empty),
    .fifo_rd_en   (B_FIFO_rd_en),
    .fifo_rd_data (B_FIFO_rd_data),
    .valid        (BVALID),
    .ready        (BREADY),
    .payload      (b_payload_s)
  );

  resp_channel_pop #(.WIDTH(R_ENTRY_WIDTH)) u_r_pop (
    .clk          (clk),
    .arst         (arst),
    .fifo_empty   (R_FIFO_empty),
    .fifo_rd_en   (R_FIFO_rd_en),
    .fifo_rd_data (R_FIFO_rd_data),
    .valid        (RVALID),
    .ready        (RREADY),
    .payload      (r_payload_s)
  );

  assign BID   = b_payload_s[B_ENTRY_WIDTH-1 -: ID_WIDTH];
  assign BRESP = b_payload_s[1:0];
  assign RID   = r_payload_s[R_ENTRY_WIDTH-1 -: ID_WIDTH];
  assign RDATA = r_payload_s[DATA_WIDTH+2 -: DATA_WIDTH];
  assign RRESP = r_payload_s[2:1];
  assign RLAST = r_payload_s[0];

  assign r_pop_s        = RVALID & RREADY;
  assign r_beat_count   = r_beat_count_q;
  assign r_burst_active = r_burst_active_q;
  assign r_last_err     = r_last_err_q;

  // Burst tracker: count non-last beats, saturate at MAX_BEATS, flag a missing RLAST
  always_comb begin
    r_beat_count_d   = r_beat_count_q;
    r_burst_active_d = r_burst_active_q;
    r_last_err_d     = r_last_err_q;
    if (r_pop_s) begin
      if (RLAST) begin
        r_beat_count_d   = '0;
        r_burst_active_d = 1'b0;
      end else begin
        r_burst_active_d = 1'b1;
        if (r_beat_count_q < CNT_W'(MAX_BEATS)) begin
          r_beat_count_d = r_beat_count_q + CNT_W'(1);
          if (r_beat_count_q == CNT_W'(MAX_BEATS - 1)) begin
            r_last_err_d = 1'b1;
          end else begin
            r_last_err_d = r_last_err_q;
          end
        end else begin
          r_beat_count_d = r_beat_count_q;
        end
      end
    end else begin
      r_beat_count_d = r_beat_count_q;
    end
  end

  // Burst tracker registers; the overrun flag is cleared only by reset
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_beat_count_q   <= '0;
      r_burst_active_q <= 1'b0;
      r_last_err_q     <= 1'b0;
    end else begin
      r_beat_count_q   <= r_beat_count_d;
      r_burst_active_q <= r_burst_active_d;
      r_last_err_q     <= r_last_err_d;
    end
  end

endmodule

// File: tb/tb_response_pop_fsm.sv
// Scoreboard bench for response_pop_fsm: directed pushes into modelled FIFOs, monitor checks pops.
module tb_response_pop_fsm;
  import response_pop_fsm_pkg::*;

  typedef struct packed {
    r_entry_t   e;
    logic [5:0] cnt;
  } r_exp_t;

  logic              clk = 1'b0;
  logic              arst = 1'b0;
  logic              B_FIFO_rd_en, R_FIFO_rd_en;
  logic [ID_W+1:0]   b_rd_data = '0;
  logic [ID_W+DATA_W+2:0] r_rd_data = '0;
  logic [ID_W-1:0]   BID, RID;
  logic [1:0]        BRESP, RRESP;
  logic [DATA_W-1:0] RDATA;
  logic              BVALID, RVALID, RLAST;
  logic              BREADY = 1'b0, RREADY = 1'b0;
  logic              r_burst_active, r_last_err;
  logic [5:0]        r_beat_count;

  b_entry_t b_fifo[$];
  r_entry_t r_fifo[$];
  b_entry_t b_exp[$];
  r_exp_t   r_exp[$];
  int b_pushes = 0, b_pops = 0, r_pushes = 0, r_pops = 0;
  int total = 0, bad = 0;

  wire B_FIFO_empty = (b_pushes == b_pops);
  wire R_FIFO_empty = (r_pushes == r_pops);

  always #5 clk = ~clk;

  response_pop_fsm dut (
    .clk(clk), .arst(arst),
    .B_FIFO_empty(B_FIFO_empty), .B_FIFO_rd_en(B_FIFO_rd_en), .B_FIFO_rd_data(b_rd_data),
    .R_FIFO_empty(R_FIFO_empty), .R_FIFO_rd_en(R_FIFO_rd_en), .R_FIFO_rd_data(r_rd_data),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .r_burst_active(r_burst_active), .r_beat_count(r_beat_count), .r_last_err(r_last_err)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_b(input logic [6:0] id, input logic [1:0] resp);
    b_entry_t e;
    e.id = id; e.resp = resp;
    b_fifo.push_back(e); b_exp.push_back(e); b_pushes++;
  endtask

  task automatic push_r(input logic [6:0] id, input logic [31:0] tag, input logic [1:0] resp,
                        input logic last, input logic [5:0] cnt);
    r_exp_t x;
    x.e.id = id; x.e.data = {32{tag}}; x.e.resp = resp; x.e.last = last; x.cnt = cnt;
    r_fifo.push_back(x.e); r_exp.push_back(x); r_pushes++;
  endtask

  // FIFO models: registered read data, cleared by the shared reset
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      b_fifo.delete(); r_fifo.delete();
      b_pops <= b_pushes; r_pops <= r_pushes;
      b_rd_data <= '0; r_rd_data <= '0;
    end else begin
      if (B_FIFO_rd_en) begin b_rd_data <= b_fifo.pop_front(); b_pops <= b_pops + 1; end
      if (R_FIFO_rd_en) begin r_rd_data <= r_fifo.pop_front(); r_pops <= r_pops + 1; end
    end
  end

  // Monitor: every handshake pops the scoreboard and compares
  always @(negedge clk) begin
    if (arst) begin
      if (BVALID && BREADY) begin
        if (b_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected got=BID %0h exp=no beat", BID);
        end else begin
          b_entry_t be;
          be = b_exp.pop_front();
          check("b_id", 64'(BID), 64'(be.id));
          check("b_resp", 64'(BRESP), 64'(be.resp));
        end
      end
      if (RVALID && RREADY) begin
        if (r_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected got=RID %0h exp=no beat", RID);
        end else begin
          r_exp_t re;
          re = r_exp.pop_front();
          check("r_id", 64'(RID), 64'(re.e.id));
          check("r_data_lo", RDATA[63:0], re.e.data[63:0]);
          check("r_data_full", 64'(RDATA == re.e.data), 64'd1);
          check("r_resp", 64'(RRESP), 64'(re.e.resp));
          check("r_last", 64'(RLAST), 64'(re.e.last));
          check("r_beat_count", 64'(r_beat_count), 64'(re.cnt));
        end
      end
    end
  end

  initial begin
    logic [7:0] rv;
    logic [DATA_W-1:0] cap_data;
    logic [6:0] cap_id;
    logic cap_last;
    int pulses;
    int pops;
    logic err_next;
    logic any_valid;

    repeat (3) @(posedge clk);
    #1 arst = 1'b1;
    @(negedge clk);
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_cnt", 64'(r_beat_count), 64'd0);
    check("rst_active", 64'(r_burst_active), 64'd0);
    check("rst_err", 64'(r_last_err), 64'd0);

    // Single B beat: rd_en cycle 0, BVALID cycle 2, gone cycle 3
    @(posedge clk); #1;
    BREADY = 1'b1; push_b(7'd5, 2'd0);
    @(negedge clk);
    check("t1_rd_en_c0", 64'(B_FIFO_rd_en), 64'd1);
    check("t1_bvalid_c0", 64'(BVALID), 64'd0);
    @(negedge clk); check("t1_bvalid_c1", 64'(BVALID), 64'd0);
    @(negedge clk); check("t1_bvalid_c2", 64'(BVALID), 64'd1);
    @(negedge clk); check("t1_bvalid_c3", 64'(BVALID), 64'd0);

    // Four-beat R burst streamed back to back
    @(posedge clk); #1;
    RREADY = 1'b1;
    for (int i = 0; i < 4; i++) push_r(7'd3, 32'hA000_0000 + 32'(i), 2'd0, (i == 3), 6'(i));
    rv = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rv[i] = RVALID;
      if (i == 3) check("t2_active_mid", 64'(r_burst_active), 64'd1);
      if (i == 6) begin
        check("t2_cnt_end", 64'(r_beat_count), 64'd0);
        check("t2_active_end", 64'(r_burst_active), 64'd0);
      end
    end
    check("t2_rvalid_pattern", 64'(rv), 64'h3C);

    // Backpressure: six words, RREADY low for five cycles
    @(posedge clk); #1;
    RREADY = 1'b0;
    for (int i = 0; i < 6; i++) push_r(7'd9, 32'hB000_0000 + 32'(i), 2'd1, (i == 5), 6'(i));
    pulses = 0;
    cap_data = '0; cap_id = '0; cap_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (R_FIFO_rd_en) pulses++;
      if (i == 2) begin
        check("t3_rvalid_up", 64'(RVALID), 64'd1);
        cap_data = RDATA; cap_id = RID; cap_last = RLAST;
      end
      if (i > 2) begin
        check("t3_rdata_stable", 64'(RDATA == cap_data), 64'd1);
        check("t3_rid_stable", 64'(RID), 64'(cap_id));
        check("t3_rlast_stable", 64'(RLAST), 64'(cap_last));
        check("t3_rvalid_held", 64'(RVALID), 64'd1);
      end
    end
    check("t3_rd_en_pulses", 64'(pulses), 64'd2);
    @(posedge clk); #1;
    RREADY = 1'b1;
    rv = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rv[i] = RVALID;
    end
    check("t3_stream_pattern", 64'(rv), 64'h3F);

    // B and R pop together with independent payloads
    @(posedge clk); #1;
    push_b(7'h2A, 2'd1);
    push_r(7'h11, 32'hC0DE_0001, 2'd2, 1'b1, 6'd0);
    repeat (3) @(negedge clk);
    check("t4_both_valid", 64'({BVALID, RVALID}), 64'h3);
    @(negedge clk);

    // Reset after the second of four beats
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_r(7'h22, 32'hD000_0000 + 32'(i), 2'd0, (i == 3), 6'(i));
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    arst = 1'b0;
    r_exp.delete(); b_exp.delete();
    #1;
    check("t5_rvalid_rst", 64'(RVALID), 64'd0);
    check("t5_cnt_rst", 64'(r_beat_count), 64'd0);
    check("t5_active_rst", 64'(r_burst_active), 64'd0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_valid = any_valid | RVALID | BVALID;
    end
    check("t5_no_stale", 64'(any_valid), 64'd0);

    // Overrun: 33 non-last beats, then a closing last beat
    @(posedge clk); #1;
    for (int i = 0; i < 33; i++) push_r(7'h33, 32'hE000_0000 + 32'(i), 2'd0, 1'b0, (i < 32) ? 6'(i) : 6'd32);
    push_r(7'h33, 32'hE000_00FF, 2'd0, 1'b1, 6'd32);
    pops = 0; err_next = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err_next) begin
        check("t6_err_rise", 64'(r_last_err), 64'd1);
        err_next = 1'b0;
      end
      if (RVALID && RREADY) begin
        pops++;
        if (pops == 32) begin
          check("t6_err_before", 64'(r_last_err), 64'd0);
          err_next = 1'b1;
        end
      end
    end
    check("t6_pops", 64'(pops), 64'd34);
    check("t6_err_sticky", 64'(r_last_err), 64'd1);
    check("t6_cnt_end", 64'(r_beat_count), 64'd0);

    for (int i = 0; i < 20 && (b_exp.size() != 0 || r_exp.size() != 0); i++) @(negedge clk);
    check("sb_b_drained", 64'(b_exp.size()), 64'd0);
    check("sb_r_drained", 64'(r_exp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
